// File: rtl/afifo_read_packer_if.sv
// Output stream of the async-FIFO read packer: a wide packed word plus its lane
// count and flush marker, moved on a valid/ready handshake.
//   out_data  : packed word, lane 0 (LSBs) is the oldest FIFO word
//   out_lanes : number of valid lanes in out_data
//   out_last  : word was produced by a flush
//   out_valid : payload valid
//   out_ready : downstream accepts when out_valid && out_ready at a clock edge
interface afifo_read_packer_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PACK_RATIO = 4,
    parameter int unsigned LANE_W     = $clog2(PACK_RATIO + 1)
) ();
    logic [DATA_WIDTH*PACK_RATIO-1:0] out_data;
    logic [LANE_W-1:0]                out_lanes;
    logic                             out_last;
    logic                             out_valid;
    logic                             out_ready;

    modport master (
        output out_data,
        output out_lanes,
        output out_last,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_lanes,
        input  out_last,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/afifo_read_packer.sv
// Read-side consumer of the async FIFO (rclk domain). Drains DATA_WIDTH words
// via rinc/rempty, packs PACK_RATIO consecutive words into one wide word and
// presents it on a valid/ready stream. A flush emits the pending partial word
// zero-padded with out_last set.
//   rclk, rrst_n : read clock, async active-low reset
//   rempty       : FIFO empty flag (rclk domain)
//   rdata        : FIFO read data, valid the cycle after rinc && !rempty
//   rinc         : FIFO read increment (combinational)
//   flush        : single-cycle request to emit the partial word
//   out_if       : packed output stream (master side)
module afifo_read_packer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PACK_RATIO = 4,
    parameter int unsigned LANE_W     = $clog2(PACK_RATIO + 1)
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    input  logic                  flush,
    afifo_read_packer_if.master   out_if
);

    localparam int unsigned WORD_W = DATA_WIDTH * PACK_RATIO;
    localparam int unsigned CNT_W  = LANE_W + 1;

    logic [LANE_W-1:0] count_q, count_d;
    logic              inflight_q, inflight_d;
    logic              flush_pend_q, flush_pend_d;
    logic [WORD_W-1:0] pack_q, pack_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic [LANE_W-1:0] out_lanes_q, out_lanes_d;
    logic              out_last_q, out_last_d;
    logic              out_valid_q, out_valid_d;

    logic              out_free;
    logic [LANE_W-1:0] count_cap;

    // Reads are only issued while the captured plus in-flight lanes still fit.
    assign rinc = rrst_n && !rempty && !flush_pend_q && !flush &&
                  ((CNT_W'(count_q) + CNT_W'(inflight_q)) < CNT_W'(PACK_RATIO));

    assign out_free = !out_valid_q || out_if.out_ready;

    // Capture, word completion, flush and output-register next state.
    always_comb begin
        pack_d       = pack_q;
        count_cap    = count_q;
        inflight_d   = rinc;
        flush_pend_d = flush_pend_q || flush;
        out_data_d   = out_data_q;
        out_lanes_d  = out_lanes_q;
        out_last_d   = out_last_q;
        out_valid_d  = out_valid_q && !out_if.out_ready;

        if (inflight_q) begin
            for (int unsigned i = 0; i < PACK_RATIO; i++) begin
                if (count_q == LANE_W'(i)) begin
                    pack_d[i*DATA_WIDTH +: DATA_WIDTH] = rdata;
                end
            end
            count_cap = count_q + LANE_W'(1);
        end

        count_d = count_cap;

        if (count_cap == LANE_W'(PACK_RATIO)) begin
            // Full word: move on this edge if the output register frees up.
            if (out_free) begin
                out_data_d   = pack_d;
                out_lanes_d  = LANE_W'(PACK_RATIO);
                out_last_d   = flush_pend_q || flush;
                out_valid_d  = 1'b1;
                count_d      = '0;
                pack_d       = '0;
                flush_pend_d = 1'b0;
            end
        end else if (flush_pend_q && !inflight_q && out_free) begin
            // Unused lanes are already zero: the pack register clears on every move.
            if (count_q != '0) begin
                out_data_d  = pack_q;
                out_lanes_d = count_q;
                out_last_d  = 1'b1;
                out_valid_d = 1'b1;
            end
            count_d      = '0;
            pack_d       = '0;
            flush_pend_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            count_q      <= '0;
            inflight_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            pack_q       <= '0;
            out_data_q   <= '0;
            out_lanes_q  <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            count_q      <= count_d;
            inflight_q   <= inflight_d;
            flush_pend_q <= flush_pend_d;
            pack_q       <= pack_d;
            out_data_q   <= out_data_d;
            out_lanes_q  <= out_lanes_d;
            out_last_q   <= out_last_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign out_if.out_data  = out_data_q;
    assign out_if.out_lanes = out_lanes_q;
    assign out_if.out_last  = out_last_q;
    assign out_if.out_valid = out_valid_q;

endmodule
